// File: rtl/s27_vector_sequencer.sv
// ---------------------------------------------------------------------------
// s27_vector_sequencer
//   Feeds 4-bit test vectors {G3,G2,G1,G0} into the s27 core. A vector is
//   accepted over a valid/ready handshake and registered onto core_g_o. It is
//   held stable for SETTLE cycles, then a one-cycle core clock enable is
//   issued. One cycle later core_g17_i is captured, reported on
//   res_valid_o/res_data_o, and folded into a MISR signature.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   start_i      synchronous clear of signature/count; aborts a vector in flight
//   vec_valid_i  vector available
//   vec_data_i   {G3,G2,G1,G0}
//   vec_ready_o  vector can be accepted this cycle
//   core_g_o     vector driven to the core
//   core_cke_o   one-cycle enable for the core flip-flops
//   core_g17_i   core output G17
//   res_valid_o  one-cycle pulse: res_data_o holds a new result
//   res_data_o   last captured G17
//   signature_o  MISR state
//   vec_count_o  vectors completed, saturating
//   busy_o       a vector is in flight
// ---------------------------------------------------------------------------
module s27_vector_sequencer #(
    parameter int unsigned      SETTLE = 2,
    parameter int unsigned      SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(16'hFFFF),
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             vec_valid_i,
    input  logic [3:0]       vec_data_i,
    output logic             vec_ready_o,
    output logic [3:0]       core_g_o,
    output logic             core_cke_o,
    input  logic             core_g17_i,
    output logic             res_valid_o,
    output logic             res_data_o,
    output logic [SIG_W-1:0] signature_o,
    output logic [CNT_W-1:0] vec_count_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PULSE,
        ST_CAPTURE
    } state_t;

    // Settle down-counter runs SETTLE-1 .. 0, so it needs to hold SETTLE-1.
    localparam int unsigned       SCNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LOAD = (SETTLE > 0) ? SCNT_W'(SETTLE - 1) : '0;

    state_t             state_q, state_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [3:0]         core_g_q, core_g_d;
    logic               cke_q, cke_d;
    logic               res_valid_q, res_valid_d;
    logic               res_data_q, res_data_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   sig_step;
    logic               accept;

    assign vec_ready_o = (state_q == ST_IDLE) & ~start_i;
    assign accept      = vec_valid_i & vec_ready_o;

    // Galois-style shift with G17 injected into the LSB.
    assign sig_step = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-1){1'b0}}, core_g17_i};

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        core_g_d    = core_g_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        sig_d       = sig_q;
        cnt_d       = cnt_q;

        if (start_i) begin
            // Abort: core_g_q intentionally keeps the last vector.
            state_d = ST_IDLE;
            sig_d   = SEED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        core_g_d = vec_data_i;
                        if (SETTLE == 0) begin
                            state_d = ST_PULSE;
                        end else begin
                            state_d = ST_SETTLE;
                            scnt_d  = SCNT_LOAD;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (scnt_q == '0) begin
                        state_d = ST_PULSE;
                    end else begin
                        scnt_d = scnt_q - 1'b1;
                    end
                end
                ST_PULSE: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b1;
                    res_data_d  = core_g17_i;
                    sig_d       = sig_step;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Enable is registered off the next state so it is glitch-free and high
    // exactly while the FSM sits in PULSE; an abort before PULSE suppresses it.
    assign cke_d = (state_d == ST_PULSE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            scnt_q      <= '0;
            core_g_q    <= '0;
            cke_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 1'b0;
            sig_q       <= SEED;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            core_g_q    <= core_g_d;
            cke_q       <= cke_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            sig_q       <= sig_d;
            cnt_q       <= cnt_d;
        end
    end

    assign core_g_o    = core_g_q;
    assign core_cke_o  = cke_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign signature_o = sig_q;
    assign vec_count_o = cnt_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_s27_vector_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for s27_vector_sequencer. Three instances share one stimulus:
//   inst 0: SETTLE=2, CNT_W=16   inst 1: SETTLE=0   inst 2: SETTLE=2, CNT_W=2
// A cycle-level model tracks "cycles since acceptance" per instance and
// predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_s27_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  = 1'b1;
    logic       start  = 1'b0;
    logic       vvalid = 1'b0;
    logic [3:0] vdata  = 4'h0;
    logic       g17    = 1'b0;

    logic        ready_w [3];
    logic [3:0]  g_w     [3];
    logic        cke_w   [3];
    logic        rv_w    [3];
    logic        rd_w    [3];
    logic [15:0] sig_w   [3];
    logic [15:0] cnt_w   [3];
    logic        busy_w  [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned ST = (gi == 1) ? 0 : 2;
        localparam int unsigned CW = (gi == 2) ? 2 : 16;
        logic [CW-1:0] cnt_loc;
        s27_vector_sequencer #(
            .SETTLE (ST),
            .SIG_W  (16),
            .POLY   (16'h1021),
            .SEED   (16'hFFFF),
            .CNT_W  (CW)
        ) u_dut (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .start_i     (start),
            .vec_valid_i (vvalid),
            .vec_data_i  (vdata),
            .vec_ready_o (ready_w[gi]),
            .core_g_o    (g_w[gi]),
            .core_cke_o  (cke_w[gi]),
            .core_g17_i  (g17),
            .res_valid_o (rv_w[gi]),
            .res_data_o  (rd_w[gi]),
            .signature_o (sig_w[gi]),
            .vec_count_o (cnt_loc),
            .busy_o      (busy_w[gi])
        );
        assign cnt_w[gi] = 16'(cnt_loc);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          pos   [3];   // 0 = idle, else cycles since acceptance
    logic [3:0]  m_g   [3];
    logic        m_rv  [3];
    logic        m_rd  [3];
    logic [15:0] m_sig [3];
    int          m_cnt [3];

    function automatic int settle_of(input int i);
        return (i == 1) ? 0 : 2;
    endfunction

    function automatic int cnt_max_of(input int i);
        return (i == 2) ? 3 : 65535;
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pos[i] = 0; m_g[i] = 4'h0; m_rv[i] = 1'b0; m_rd[i] = 1'b0;
            m_sig[i] = 16'hFFFF; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            m_rv[i] = 1'b0;
            if (start) begin
                pos[i] = 0; m_sig[i] = 16'hFFFF; m_cnt[i] = 0;
            end else if (pos[i] == settle_of(i) + 2) begin
                m_rv[i]  = 1'b1;
                m_rd[i]  = g17;
                m_sig[i] = misr(m_sig[i], g17);
                if (m_cnt[i] < cnt_max_of(i)) m_cnt[i]++;
                pos[i] = 0;
                if (i == 0)
                    $display("txn inst0 vec=%h g17=%0d sig=%04h cnt=%0d", m_g[i], g17, m_sig[i], m_cnt[i]);
            end else if (pos[i] > 0) begin
                pos[i]++;
            end else if (vvalid) begin
                m_g[i] = vdata; pos[i] = 1;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 3; i++) begin
            chk("ready", i, 32'(ready_w[i]), 32'((pos[i] == 0) && !start));
            chk("busy",  i, 32'(busy_w[i]),  32'(pos[i] != 0));
            chk("cke",   i, 32'(cke_w[i]),   32'(pos[i] == settle_of(i) + 1));
            chk("rv",    i, 32'(rv_w[i]),    32'(m_rv[i]));
            chk("rd",    i, 32'(rd_w[i]),    32'(m_rd[i]));
            chk("core_g",i, 32'(g_w[i]),     32'(m_g[i]));
            chk("sig",   i, 32'(sig_w[i]),   32'(m_sig[i]));
            chk("cnt",   i, 32'(cnt_w[i]),   32'(m_cnt[i]));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic v, input logic [3:0] d, input logic g);
        start = s; vvalid = v; vdata = d; g17 = g;
    endtask

    task automatic mid();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic fin();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input logic s, input logic v, input logic [3:0] d, input logic g);
        drive(s, v, d, g);
        mid();
        fin();
    endtask

    // Asserts reset asynchronously right now, checks reset values, releases
    // it at the next falling edge and returns 1 after the following rising edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rst;
        bit          s;
        bit          v;
        logic [3:0]  d;
        bit          g;
        bit          e_ready;
        bit          e_busy;
        bit          e_cke;
        bit          e_rv;
        bit          e_rd;
        logic [3:0]  e_g;
        logic [15:0] e_sig;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit v, input logic [3:0] d, input bit g,
                                input bit er, input bit eb, input bit ec, input bit ev, input bit ed,
                                input logic [3:0] eg, input logic [15:0] es, input logic [15:0] en);
        vec_t r;
        r.rst = rst; r.s = 1'b0; r.v = v; r.d = d; r.g = g;
        r.e_ready = er; r.e_busy = eb; r.e_cke = ec; r.e_rv = ev; r.e_rd = ed;
        r.e_g = eg; r.e_sig = es; r.e_cnt = en;
        return r;
    endfunction

    vec_t tbl [12];

    initial begin
        int acc, rvn, last, k;

        // Vector 4'hA accepted in cycle 0; CKE in cycle 3; result in cycle 5.
        tbl[0]  = mk(1, 1, 4'hA, 1, 1, 0, 0, 0, 0, 4'h0, 16'hFFFF, 0);
        tbl[1]  = mk(0, 0, 4'h0, 1, 0, 1, 0, 0, 0, 4'hA, 16'hFFFF, 0);
        tbl[2]  = mk(0, 0, 4'h0, 1, 0, 1, 0, 0, 0, 4'hA, 16'hFFFF, 0);
        tbl[3]  = mk(0, 0, 4'h0, 1, 0, 1, 1, 0, 0, 4'hA, 16'hFFFF, 0);
        tbl[4]  = mk(0, 0, 4'h0, 1, 0, 1, 0, 0, 0, 4'hA, 16'hFFFF, 0);
        tbl[5]  = mk(0, 0, 4'h0, 1, 1, 0, 0, 1, 1, 4'hA, 16'hEFDE, 1);
        tbl[6]  = mk(1, 1, 4'hA, 0, 1, 0, 0, 0, 0, 4'h0, 16'hFFFF, 0);
        tbl[7]  = mk(0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 4'hA, 16'hFFFF, 0);
        tbl[8]  = mk(0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 4'hA, 16'hFFFF, 0);
        tbl[9]  = mk(0, 0, 4'h0, 0, 0, 1, 1, 0, 0, 4'hA, 16'hFFFF, 0);
        tbl[10] = mk(0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 4'hA, 16'hFFFF, 0);
        tbl[11] = mk(0, 0, 4'h0, 0, 1, 0, 0, 1, 0, 4'hA, 16'hEFDF, 1);

        do_reset();

        for (int r = 0; r < 12; r++) begin
            if (tbl[r].rst) do_reset();
            drive(tbl[r].s, tbl[r].v, tbl[r].d, tbl[r].g);
            mid();
            chk("tbl_ready", r, 32'(ready_w[0]), 32'(tbl[r].e_ready));
            chk("tbl_busy",  r, 32'(busy_w[0]),  32'(tbl[r].e_busy));
            chk("tbl_cke",   r, 32'(cke_w[0]),   32'(tbl[r].e_cke));
            chk("tbl_rv",    r, 32'(rv_w[0]),    32'(tbl[r].e_rv));
            chk("tbl_rd",    r, 32'(rd_w[0]),    32'(tbl[r].e_rd));
            chk("tbl_g",     r, 32'(g_w[0]),     32'(tbl[r].e_g));
            chk("tbl_sig",   r, 32'(sig_w[0]),   32'(tbl[r].e_sig));
            chk("tbl_cnt",   r, 32'(cnt_w[0]),   32'(tbl[r].e_cnt));
            fin();
        end

        // START during SETTLE aborts the vector after a completed one.
        do_reset();
        step(0, 1, 4'h3, 1);
        for (int c = 0; c < 5; c++) step(0, 0, 4'h0, 1);
        step(0, 1, 4'h5, 1);          // accept
        step(0, 0, 4'h0, 1);          // SETTLE 1
        drive(1, 0, 4'h0, 1);         // START in last SETTLE cycle
        mid();
        chk("t3_ready_start", 0, 32'(ready_w[0]), 32'd0);
        chk("t3_busy_start",  0, 32'(busy_w[0]),  32'd1);
        fin();
        drive(0, 0, 4'h0, 1);
        mid();
        chk("t3_busy_after", 0, 32'(busy_w[0]), 32'd0);
        chk("t3_sig_after",  0, 32'(sig_w[0]),  32'hFFFF);
        chk("t3_cnt_after",  0, 32'(cnt_w[0]),  32'd0);
        chk("t3_g_kept",     0, 32'(g_w[0]),    32'h5);
        fin();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 4'h0, 1);
            mid();
            if (cke_w[0] || rv_w[0]) acc++;
            fin();
        end
        chk("t3_no_pulse", 0, 32'(acc), 32'd0);

        // SETTLE=0 instance: back-to-back acceptances every 3 cycles.
        do_reset();
        acc = 0; rvn = 0; last = -1;
        for (int c = 0; c < 16; c++) begin
            drive(0, acc < 4, 4'(c), c[0]);
            mid();
            if (ready_w[1] && vvalid) begin
                if (last >= 0) chk("t4_gap", 1, 32'(c - last), 32'd3);
                last = c;
                acc++;
            end
            if (rv_w[1]) rvn++;
            fin();
        end
        chk("t4_accepts", 1, 32'(acc), 32'd4);
        chk("t4_results", 1, 32'(rvn), 32'd4);

        // CNT_W=2 instance: count saturates at 3.
        do_reset();
        k = 0;
        for (int c = 0; c < 40; c++) begin
            drive(0, 1, 4'(c), ~c[0]);
            mid();
            if (rv_w[2]) begin
                chk("t5_cnt", 2, 32'(cnt_w[2]), 32'((k + 1 > 3) ? 3 : k + 1));
                k++;
            end
            fin();
        end
        chk("t5_results", 2, 32'(k >= 5), 32'd1);

        // Reset asserted during the PULSE cycle.
        do_reset();
        step(0, 1, 4'hC, 1);
        step(0, 0, 4'h0, 1);
        step(0, 0, 4'h0, 1);
        chk("t6_cke_pre", 0, 32'(cke_w[0]), 32'd1);
        #2;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(0, c == 0, 4'h6, 1);
            mid();
            if (c == 5) begin
                chk("t6_rv",  0, 32'(rv_w[0]),  32'd1);
                chk("t6_sig", 0, 32'(sig_w[0]), 32'hEFDE);
                chk("t6_g",   0, 32'(g_w[0]),   32'h6);
            end
            fin();
        end

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
